proc_debug_controller: RTL and testbench
========================================

Name: proc_debug_controller

Overview:
- Host-side sequencer for the 18-bit processor core.
- Holds the core in reset, releases it, and detects its wait_for_continue halt.
- While the core is halted, takes over the data-RAM port so a host can read and write memory and read registers/ip over the core debug interface; then resumes the core through the continue handshake.
- Sits between the processor, the data ram and a host command link (UART bridge or testbench).

Parameters:
ADDR_SIZE, 18, data-RAM address width
WORD_SIZE, 18, data word width
RESET_CYCLES, 2, clocks cpu_reset is held after controller reset or a RESET_CPU command (min 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low controller reset
host_cmd_valid  in  1  command valid
host_cmd_ready  out  1  command accepted when valid&ready
host_cmd_op  in  3  0 RESET_CPU, 1 CONTINUE, 2 READ_MEM, 3 WRITE_MEM, 4 READ_REG, 5-7 invalid
host_cmd_addr  in  ADDR_SIZE  memory address, or register index in [3:0] (0-7 rN, 8 ip)
host_cmd_data  in  WORD_SIZE  write data
host_rsp_valid  out  1  response valid, held until ready
host_rsp_ready  in  1  response consumed
host_rsp_data  out  WORD_SIZE  read data or echoed write data; 0 on error
host_rsp_err  out  1  command rejected
host_halted  out  1  core parked in wait_for_continue, RAM owned by controller
cpu_reset  out  1  active-high reset to processor
cpu_wait_for_continue  in  1  from processor
cpu_continue  out  1  to processor wait_continue_execution
cpu_mem_we / cpu_mem_addr / cpu_mem_din  in  1/ADDR_SIZE/WORD_SIZE  processor data port
cpu_mem_dout  out  WORD_SIZE  = ram_dout always
ram_we / ram_addr / ram_din  out  1/ADDR_SIZE/WORD_SIZE  to data ram
ram_dout  in  WORD_SIZE  from data ram
dbg_get_param  out  1  debug read enable (DEBUG_REG_READ_EN only)
dbg_reg_addr  out  4  debug register index (DEBUG_REG_READ_EN only)
dbg_data_out  in  WORD_SIZE  debug read data (DEBUG_REG_READ_EN only)

Behaviour:
- Reset values: state RST_HOLD, cpu_reset=1, cpu_continue=0, host_cmd_ready=0, host_rsp_valid=0, host_rsp_data=0, host_rsp_err=0, host_halted=0, ram_we=0, dbg_get_param=0, dbg_reg_addr=0, hold counter=0.
- RAM mux:
  - In RST_HOLD/RUN/CONT, ram_* = cpu_mem_*.
  - Otherwise ram_* is driven by the controller; cpu_mem_we is ignored.
- RST_HOLD: cpu_reset=1 for exactly RESET_CYCLES clocks, then RUN.
- RUN: host_cmd_ready=1.
  - Accepted RESET_CPU -> RST_HOLD (priority over a halt in the same cycle).
  - Any other accepted op -> RSP with err=1, return state RUN.
  - Otherwise cpu_wait_for_continue=1 -> HALTED next clock.
- HALTED: host_halted=1, host_cmd_ready=1.
  - READ_MEM -> MEM_RD: ram_addr=cmd addr for 1 clock.
  - MEM_RD -> MEM_CAP: rsp_data<=ram_dout. Read latency 1 clock after address, covering combinational and registered-read RAM.
  - WRITE_MEM -> MEM_WR: ram_we=1 for exactly one clock; rsp_data=written data.
  - READ_REG -> REG_RD: dbg_get_param=1, dbg_reg_addr=addr[3:0] for 1 clock.
  - REG_RD -> REG_CAP: rsp_data<=dbg_data_out. Index >8 -> err=1 without touching the debug port.
  - CONTINUE -> CONT.
  - RESET_CPU -> RST_HOLD. It is not acknowledged with a response.
  - Invalid op -> RSP err=1.
  - All HALTED responses return to HALTED.
- CONT: cpu_continue=1 until cpu_wait_for_continue samples 0, then RSP (err=0, data=0), return RUN. cpu_continue drops the cycle RSP is entered.
- RSP: host_rsp_valid=1 with stable data/err until host_rsp_ready, then return state; host_cmd_ready=0 throughout. No back-to-back acceptance: each command gets exactly one response (except RESET_CPU).
- Halt raised while in RSP from RUN: detected on return to RUN.
- Async reset mid-operation: immediate return to reset values, pending response discarded, ram_we forced 0, core re-reset.
- host_halted deasserts the clock CONT is entered.

Optional Feature:
- Macro DEBUG_REG_READ_EN.
- Defined: dbg_* ports exist and READ_REG behaves as above.
- Undefined: dbg_* ports are absent, and READ_REG is answered err=1, data=0, like an invalid op.

Decomposition:
- Package proc_debug_pkg: cmd_op_t enum (RESET_CPU..READ_REG), ctrl_state_t enum (RST_HOLD, RUN, HALTED, MEM_RD, MEM_CAP, MEM_WR, REG_RD, REG_CAP, CONT, RSP), constant REG_IP_INDEX=8.
- One sub-module, proc_debug_ram_mux: combinational RAM port select between core and controller.

Test Plan:
- Release reset -> cpu_reset high exactly 2 clocks; program reaching the wait instruction -> host_halted=1 within 1 clock of cpu_wait_for_continue.
- Halted, WRITE_MEM addr 5 data 3FFFF, then READ_MEM 5 -> rsp_data=3FFFF, err=0; mem[5]=3FFFF; exactly one ram_we pulse.
- Halted, READ_REG 0..8 (DEBUG_REG_READ_EN) -> rsp_data equals processor18.registers.regs[i] / ip; READ_REG 9 -> err=1, dbg_get_param never asserted.
- CONTINUE -> cpu_continue held until wait_for_continue falls; one response err=0; next halt re-detected.
- READ_MEM in RUN -> err=1, data=0; cpu_mem traffic unaffected; op 7 while halted -> err=1.
- Hold host_rsp_ready=0 for 10 clocks -> response stable; assert reset mid-MEM_WR -> ram_we=0 immediately, cpu_reset=1, rsp_valid=0.

Source files
------------

// File: rtl/proc_debug_pkg.sv
// Shared types and constants for the processor debug controller.
package proc_debug_pkg;

  typedef enum logic [2:0] {
    RESET_CPU = 3'd0,
    CONTINUE  = 3'd1,
    READ_MEM  = 3'd2,
    WRITE_MEM = 3'd3,
    READ_REG  = 3'd4
  } cmd_op_t;

  typedef enum logic [3:0] {
    RST_HOLD,
    RUN,
    HALTED,
    MEM_RD,
    MEM_CAP,
    MEM_WR,
    REG_RD,
    REG_CAP,
    CONT,
    RSP
  } ctrl_state_t;

  // Debug register indices 0-7 are r0..r7, 8 is the instruction pointer.
  localparam logic [3:0] REG_IP_INDEX = 4'd8;

  function automatic logic reg_index_valid(input logic [3:0] idx);
    return idx <= REG_IP_INDEX;
  endfunction

endpackage

// File: rtl/proc_debug_ram_mux.sv
// Data-RAM port select between the processor core and the debug controller.
module proc_debug_ram_mux #(
  parameter int unsigned ADDR_SIZE = 18,
  parameter int unsigned WORD_SIZE = 18
) (
  input  logic                 sel_ctrl_i,
  input  logic                 cpu_we_en_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_SIZE-1:0] cpu_addr_i,
  input  logic [WORD_SIZE-1:0] cpu_din_i,
  input  logic                 ctrl_we_i,
  input  logic [ADDR_SIZE-1:0] ctrl_addr_i,
  input  logic [WORD_SIZE-1:0] ctrl_din_i,
  output logic                 ram_we_o,
  output logic [ADDR_SIZE-1:0] ram_addr_o,
  output logic [WORD_SIZE-1:0] ram_din_o
);

  always_comb begin
    if (sel_ctrl_i) begin
      ram_we_o   = ctrl_we_i;
      ram_addr_o = ctrl_addr_i;
      ram_din_o  = ctrl_din_i;
    end else begin
      // A core held in reset must never write memory.
      ram_we_o   = cpu_we_i & cpu_we_en_i;
      ram_addr_o = cpu_addr_i;
      ram_din_o  = cpu_din_i;
    end
  end

endmodule

// File: rtl/proc_debug_controller.sv
// Host-side reset/halt/continue sequencer and memory/register debug access for the 18-bit core.
// Optional: define DEBUG_REG_READ_EN to add the dbg_* register read port.
module proc_debug_controller
  import proc_debug_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = 18,
  parameter int unsigned WORD_SIZE    = 18,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 host_cmd_valid,
  output logic                 host_cmd_ready,
  input  logic [2:0]           host_cmd_op,
  input  logic [ADDR_SIZE-1:0] host_cmd_addr,
  input  logic [WORD_SIZE-1:0] host_cmd_data,
  output logic                 host_rsp_valid,
  input  logic                 host_rsp_ready,
  output logic [WORD_SIZE-1:0] host_rsp_data,
  output logic                 host_rsp_err,
  output logic                 host_halted,
  output logic                 cpu_reset,
  input  logic                 cpu_wait_for_continue,
  output logic                 cpu_continue,
  input  logic                 cpu_mem_we,
  input  logic [ADDR_SIZE-1:0] cpu_mem_addr,
  input  logic [WORD_SIZE-1:0] cpu_mem_din,
  output logic [WORD_SIZE-1:0] cpu_mem_dout,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  input  logic [WORD_SIZE-1:0] ram_dout
`ifdef DEBUG_REG_READ_EN
  ,
  output logic                 dbg_get_param,
  output logic [3:0]           dbg_reg_addr,
  input  logic [WORD_SIZE-1:0] dbg_data_out
`endif
);

  localparam int unsigned CntW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(RESET_CYCLES - 1);

  ctrl_state_t            state_q, state_d;
  ctrl_state_t            ret_q, ret_d;
  logic [CntW-1:0]        hold_q, hold_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic cmd_fire;
  logic sel_ctrl;
  logic ctrl_we;
  logic cpu_we_en;

  assign host_cmd_ready = (state_q == RUN) || (state_q == HALTED);
  assign cmd_fire       = host_cmd_valid && host_cmd_ready;
  assign host_rsp_data  = rsp_data_q;
  assign host_rsp_err   = rsp_err_q;
  assign cpu_mem_dout   = ram_dout;
  assign cpu_we_en      = (state_q != RST_HOLD);

  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    hold_d         = hold_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    host_rsp_valid = 1'b0;
    host_halted    = 1'b0;
    cpu_reset      = 1'b0;
    cpu_continue   = 1'b0;
    ctrl_we        = 1'b0;
    sel_ctrl       = 1'b1;

    unique case (state_q)
      RST_HOLD: begin
        sel_ctrl  = 1'b0;
        cpu_reset = 1'b1;
        if (hold_q == HoldLast) begin
          hold_d  = '0;
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        sel_ctrl = 1'b0;
        if (cmd_fire) begin
          if (cmd_op_t'(host_cmd_op) == RESET_CPU) begin
            hold_d  = '0;
            state_d = RST_HOLD;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            ret_d      = RUN;
            state_d    = RSP;
          end
        end else if (cpu_wait_for_continue) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        host_halted = 1'b1;
        if (cmd_fire) begin
          ret_d      = HALTED;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          addr_d     = host_cmd_addr;
          wdata_d    = host_cmd_data;
          unique case (cmd_op_t'(host_cmd_op))
            RESET_CPU: begin
              hold_d  = '0;
              state_d = RST_HOLD;
            end
            CONTINUE:  state_d = CONT;
            READ_MEM:  state_d = MEM_RD;
            WRITE_MEM: state_d = MEM_WR;
            READ_REG: begin
`ifdef DEBUG_REG_READ_EN
              if (reg_index_valid(host_cmd_addr[3:0])) begin
                state_d = REG_RD;
              end else begin
                rsp_err_d = 1'b1;
                state_d   = RSP;
              end
`else
              rsp_err_d = 1'b1;
              state_d   = RSP;
`endif
            end
            default: begin
              rsp_err_d = 1'b1;
              state_d   = RSP;
            end
          endcase
        end
      end
      MEM_RD: begin
        host_halted = 1'b1;
        state_d     = MEM_CAP;
      end
      MEM_CAP: begin
        // Address held across both cycles, so registered and combinational RAMs both fit.
        host_halted = 1'b1;
        rsp_data_d  = ram_dout;
        state_d     = RSP;
      end
      MEM_WR: begin
        host_halted = 1'b1;
        ctrl_we     = 1'b1;
        rsp_data_d  = wdata_q;
        state_d     = RSP;
      end
      REG_RD: begin
        host_halted = 1'b1;
        state_d     = REG_CAP;
      end
      REG_CAP: begin
        host_halted = 1'b1;
`ifdef DEBUG_REG_READ_EN
        rsp_data_d  = dbg_data_out;
`else
        rsp_err_d   = 1'b1;
`endif
        state_d     = RSP;
      end
      CONT: begin
        sel_ctrl     = 1'b0;
        cpu_continue = 1'b1;
        if (!cpu_wait_for_continue) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          ret_d      = RUN;
          state_d    = RSP;
        end
      end
      RSP: begin
        // A running core keeps its memory port while the host drains an error response.
        sel_ctrl       = (ret_q == HALTED);
        host_halted    = (ret_q == HALTED);
        host_rsp_valid = 1'b1;
        if (host_rsp_ready) begin
          state_d = ret_q;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

`ifdef DEBUG_REG_READ_EN
  assign dbg_get_param = (state_q == REG_RD);
  assign dbg_reg_addr  = ((state_q == REG_RD) || (state_q == REG_CAP)) ? addr_q[3:0] : 4'd0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_HOLD;
      ret_q      <= RUN;
      hold_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  proc_debug_ram_mux #(
    .ADDR_SIZE(ADDR_SIZE),
    .WORD_SIZE(WORD_SIZE)
  ) u_ram_mux (
    .sel_ctrl_i  (sel_ctrl),
    .cpu_we_en_i (cpu_we_en),
    .cpu_we_i    (cpu_mem_we),
    .cpu_addr_i  (cpu_mem_addr),
    .cpu_din_i   (cpu_mem_din),
    .ctrl_we_i   (ctrl_we),
    .ctrl_addr_i (addr_q),
    .ctrl_din_i  (wdata_q),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din)
  );

endmodule

// File: tb/tb_proc_debug_controller.sv
// Scoreboard bench for proc_debug_controller with a registered-read RAM and a toy core model.
module tb_proc_debug_controller;
  import proc_debug_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        host_cmd_valid = 1'b0;
  logic        host_cmd_ready;
  logic [2:0]  host_cmd_op = 3'd0;
  logic [17:0] host_cmd_addr = '0;
  logic [17:0] host_cmd_data = '0;
  logic        host_rsp_valid;
  logic        host_rsp_ready = 1'b1;
  logic [17:0] host_rsp_data;
  logic        host_rsp_err;
  logic        host_halted;
  logic        cpu_reset;
  logic        cpu_wait_for_continue = 1'b0;
  logic        cpu_continue;
  logic        cpu_mem_we = 1'b0;
  logic [17:0] cpu_mem_addr = '0;
  logic [17:0] cpu_mem_din = '0;
  logic [17:0] cpu_mem_dout;
  logic        ram_we;
  logic [17:0] ram_addr;
  logic [17:0] ram_din;
  logic [17:0] ram_dout = '0;
`ifdef DEBUG_REG_READ_EN
  logic        dbg_get_param;
  logic [3:0]  dbg_reg_addr;
  logic [17:0] dbg_data_out = '0;
  int          gp_cnt = 0;
`endif

  typedef struct packed {
    logic [17:0] data;
    logic        err;
  } rsp_t;

  rsp_t        sb_q[$];
  rsp_t        exp_r;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        halt_req = 1'b0;
  int          cont_cnt = 0;
  int          we_cnt = 0;
  logic [17:0] mem [256] = '{default: '0};

  always #5 clock = ~clock;

  proc_debug_controller dut (
    .clock                 (clock),
    .reset                 (reset),
    .host_cmd_valid        (host_cmd_valid),
    .host_cmd_ready        (host_cmd_ready),
    .host_cmd_op           (host_cmd_op),
    .host_cmd_addr         (host_cmd_addr),
    .host_cmd_data         (host_cmd_data),
    .host_rsp_valid        (host_rsp_valid),
    .host_rsp_ready        (host_rsp_ready),
    .host_rsp_data         (host_rsp_data),
    .host_rsp_err          (host_rsp_err),
    .host_halted           (host_halted),
    .cpu_reset             (cpu_reset),
    .cpu_wait_for_continue (cpu_wait_for_continue),
    .cpu_continue          (cpu_continue),
    .cpu_mem_we            (cpu_mem_we),
    .cpu_mem_addr          (cpu_mem_addr),
    .cpu_mem_din           (cpu_mem_din),
    .cpu_mem_dout          (cpu_mem_dout),
    .ram_we                (ram_we),
    .ram_addr              (ram_addr),
    .ram_din               (ram_din),
    .ram_dout              (ram_dout)
`ifdef DEBUG_REG_READ_EN
    ,
    .dbg_get_param         (dbg_get_param),
    .dbg_reg_addr          (dbg_reg_addr),
    .dbg_data_out          (dbg_data_out)
`endif
  );

  function automatic logic [17:0] reg_val(input logic [3:0] i);
    return 18'h2A5A0 + {14'd0, i} * 18'h111;
  endfunction

  // Registered-read data RAM.
  always @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_din;
      we_cnt <= we_cnt + 1;
    end
    ram_dout <= mem[ram_addr[7:0]];
  end

  // Core model: parks on halt_req, leaves the wait three clocks into the continue handshake.
  always @(posedge clock) begin
    if (cpu_reset) begin
      cpu_wait_for_continue <= 1'b0;
      cont_cnt <= 0;
    end else if (cpu_wait_for_continue) begin
      if (cpu_continue) begin
        if (cont_cnt == 2) cpu_wait_for_continue <= 1'b0;
        cont_cnt <= cont_cnt + 1;
      end
    end else if (halt_req) begin
      cpu_wait_for_continue <= 1'b1;
      cont_cnt <= 0;
    end
  end

`ifdef DEBUG_REG_READ_EN
  always @(posedge clock) begin
    if (dbg_get_param) begin
      dbg_data_out <= reg_val(dbg_reg_addr);
      gp_cnt <= gp_cnt + 1;
    end
  end
`endif

  task automatic send_cmd(input logic [2:0] op, input logic [17:0] addr, input logic [17:0] data);
    logic ok;
    ok = 1'b0;
    host_cmd_valid = 1'b1;
    host_cmd_op    = op;
    host_cmd_addr  = addr;
    host_cmd_data  = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (host_cmd_ready) ok = 1'b1;
      else @(negedge clock);
    end
    if (ok) @(posedge clock);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: op %0d never accepted, ready=%b required 1", op, host_cmd_ready);
    end
    @(negedge clock);
    host_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [17:0] d, output logic e);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (host_rsp_valid) seen = 1'b1;
      else @(negedge clock);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", host_rsp_valid);
    end
    d = host_rsp_data;
    e = host_rsp_err;
    @(negedge clock);
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b0;
    cpu_mem_we = 1'b1;
    cpu_mem_addr = 18'd10;
    cpu_mem_din = 18'h00155;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({cpu_reset, host_cmd_ready, host_rsp_valid, host_halted, ram_we, cpu_continue,
         host_rsp_err} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 1000000", {cpu_reset, host_cmd_ready,
               host_rsp_valid, host_halted, ram_we, cpu_continue, host_rsp_err});
    end
    n_checks++;
    if (host_rsp_data !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 00000", host_rsp_data);
    end
    reset = 1'b1;
    #1;
    cnt = 0;
    while (cpu_reset && cnt < 20) begin
      cnt++;
      @(negedge clock);
    end
    n_checks++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL reset_hold: cpu_reset high %0d clocks required 2", cnt);
    end
  endtask

  task automatic test_run_error();
    logic [17:0] d;
    logic        e;
    n_checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 18'd10, 18'h00155}) begin
      n_fail++;
      $display("FAIL run_passthru: got we=%b addr=%h din=%h required 1/0000a/00155",
               ram_we, ram_addr, ram_din);
    end
    sb_q.push_back('{data: 18'h0, err: 1'b1});
    send_cmd(READ_MEM, 18'd5, 18'h0);
    n_checks++;
    if (ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL run_rsp_passthru: ram_we=%b required 1", ram_we);
    end
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL run_read_err: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
  endtask

  task automatic test_halt();
    int i;
    halt_req = 1'b1;
    i = 0;
    while (!cpu_wait_for_continue && i < 20) begin
      i++;
      @(negedge clock);
    end
    @(negedge clock);
    n_checks++;
    if (host_halted !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_detect: halted=%b ram_we=%b required 1/0", host_halted, ram_we);
    end
  endtask

  task automatic test_mem();
    logic [17:0] d;
    logic        e;
    int          w0;
    w0 = we_cnt;
    sb_q.push_back('{data: 18'h3FFFF, err: 1'b0});
    send_cmd(WRITE_MEM, 18'd5, 18'h3FFFF);
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL mem_write: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
    sb_q.push_back('{data: 18'h3FFFF, err: 1'b0});
    sb_q.push_back('{data: 18'h00155, err: 1'b0});
    send_cmd(READ_MEM, 18'd5, 18'h0);
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL mem_read5: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
    send_cmd(READ_MEM, 18'd10, 18'h0);
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL mem_read10: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
    n_checks++;
    if (mem[5] !== 18'h3FFFF || we_cnt - w0 != 1) begin
      n_fail++;
      $display("FAIL mem_we_pulse: mem5=%h pulses=%0d required 3ffff/1", mem[5], we_cnt - w0);
    end
  endtask

  task automatic test_reg();
    logic [17:0] d;
    logic        e;
`ifdef DEBUG_REG_READ_EN
    int g0;
    for (int i = 0; i <= 8; i++) begin
      sb_q.push_back('{data: reg_val(4'(i)), err: 1'b0});
      send_cmd(READ_REG, 18'(i), 18'h0);
      wait_rsp(d, e);
      exp_r = sb_q.pop_front();
      n_checks++;
      if ({d, e} !== exp_r) begin
        n_fail++;
        $display("FAIL reg_read r%0d: got %h/%b required %h/%b", i, d, e, exp_r.data, exp_r.err);
      end
    end
    g0 = gp_cnt;
`else
    sb_q.push_back('{data: 18'h0, err: 1'b1});
    send_cmd(READ_REG, 18'd3, 18'h0);
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL reg_read_off: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
`endif
    sb_q.push_back('{data: 18'h0, err: 1'b1});
    send_cmd(READ_REG, 18'd9, 18'h0);
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL reg_read9: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
`ifdef DEBUG_REG_READ_EN
    n_checks++;
    if (gp_cnt != g0) begin
      n_fail++;
      $display("FAIL reg9_no_dbg: get_param pulses %0d required 0", gp_cnt - g0);
    end
`endif
  endtask

  task automatic test_invalid();
    logic [17:0] d;
    logic        e;
    sb_q.push_back('{data: 18'h0, err: 1'b1});
    send_cmd(3'd7, 18'd1, 18'h1234);
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL invalid_op: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
    n_checks++;
    if (host_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_return: halted=%b required 1", host_halted);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] snap_d;
    logic        snap_e;
    logic        stable;
    int          i;
    host_rsp_ready = 1'b0;
    sb_q.push_back('{data: 18'h3FFFF, err: 1'b0});
    send_cmd(READ_MEM, 18'd5, 18'h0);
    i = 0;
    while (!host_rsp_valid && i < 20) begin
      i++;
      @(negedge clock);
    end
    snap_d = host_rsp_data;
    snap_e = host_rsp_err;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!host_rsp_valid || host_cmd_ready || host_rsp_data !== snap_d ||
          host_rsp_err !== snap_e) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL rsp_hold: valid=%b ready=%b data=%h required stable 1/0/%h",
               host_rsp_valid, host_cmd_ready, host_rsp_data, snap_d);
    end
    host_rsp_ready = 1'b1;
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({snap_d, snap_e} !== exp_r) begin
      n_fail++;
      $display("FAIL rsp_hold_data: got %h/%b required %h/%b", snap_d, snap_e,
               exp_r.data, exp_r.err);
    end
    @(negedge clock);
    n_checks++;
    if (host_rsp_valid !== 1'b0 || host_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_drain: valid=%b halted=%b required 0/1", host_rsp_valid, host_halted);
    end
  endtask

  task automatic test_continue();
    logic [17:0] d;
    logic        e;
    logic        held;
    int          cycles;
    int          i;
    halt_req = 1'b0;
    sb_q.push_back('{data: 18'h0, err: 1'b0});
    send_cmd(CONTINUE, 18'h0, 18'h0);
    n_checks++;
    if (host_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_halted: halted=%b required 0", host_halted);
    end
    held = 1'b1;
    cycles = 0;
    for (i = 0; i < 50 && !host_rsp_valid; i++) begin
      if (cpu_continue) cycles++;
      if (cpu_wait_for_continue && !cpu_continue) held = 1'b0;
      @(negedge clock);
    end
    // Core model drops the wait after 3 continue clocks; the controller sees it one clock later.
    n_checks++;
    if (!held || cycles != 4 || cpu_continue !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_handshake: held=%b cycles=%0d cont=%b required 1/4/0", held, cycles,
               cpu_continue);
    end
    wait_rsp(d, e);
    exp_r = sb_q.pop_front();
    n_checks++;
    if ({d, e} !== exp_r) begin
      n_fail++;
      $display("FAIL cont_rsp: got %h/%b required %h/%b", d, e, exp_r.data, exp_r.err);
    end
    halt_req = 1'b1;
    i = 0;
    while (!host_halted && i < 20) begin
      i++;
      @(negedge clock);
    end
    n_checks++;
    if (host_halted !== 1'b1) begin
      n_fail++;
      $display("FAIL rehalt: halted=%b required 1", host_halted);
    end
  endtask

  task automatic test_reset_mid_write();
    int i;
    send_cmd(WRITE_MEM, 18'd20, 18'h12345);
    n_checks++;
    if (ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midwr_we: ram_we=%b required 1", ram_we);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ram_we, cpu_reset, host_rsp_valid, host_halted} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midwr_reset: got %b required 0100",
               {ram_we, cpu_reset, host_rsp_valid, host_halted});
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (mem[20] === 18'h12345) begin
      n_fail++;
      $display("FAIL midwr_mem: mem20=%h required not 12345", mem[20]);
    end
    reset = 1'b1;
    i = 0;
    while (cpu_reset && i < 20) begin
      i++;
      @(negedge clock);
    end
    n_checks++;
    if (cpu_reset !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL midwr_recover: cpu_reset=%b pending=%0d required 0/0", cpu_reset,
               sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_run_error();
    test_halt();
    test_mem();
    test_reg();
    test_invalid();
    test_back_to_back();
    test_continue();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
